// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Valid/ready pipeline register with an optional skid entry, flush and
//   freeze controls, and a saturating count of entries discarded by flush.
//
//   Parameters
//     DATA_W    payload width (1..512)
//     SKID      1: two entries (head + skid), full throughput with registered
//               in_ready; 0: single register, in_ready looks at out_ready
//     FLUSH_VAL value held in the data registers after reset or flush
//
//   Ports
//     clk        clock, all state changes on its rising edge
//     rst        synchronous reset, active low
//     flush      discard all held entries this cycle (beats freeze)
//     freeze     hold all state, accept nothing, emit nothing
//     in_valid   / in_ready / in_data     upstream handshake
//     out_valid  / out_ready / out_data   downstream handshake (head entry)
//     occupancy  number of held entries (0..2)
//     flush_cnt  saturating count of valid entries discarded by flush
module pipe_stage_reg #(
  parameter int unsigned         DATA_W    = 128,
  parameter int unsigned         SKID      = 1,
  parameter logic [DATA_W-1:0]   FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [DATA_W-1:0] head_q,      head_d;
  logic [DATA_W-1:0] skid_q,      skid_d;
  logic [15:0]       flush_cnt_q, flush_cnt_d;

  logic        active;
  logic        push;
  logic        pop;
  logic [1:0]  occ_raw;
  logic [16:0] flush_sum;

  // The state encoding doubles as the entry count.
  assign occ_raw = state_q;

  // Handshakes are only live when the block is out of reset and neither
  // flushing nor frozen.
  assign active    = rst & ~freeze & ~flush;
  assign out_valid = (state_q != ST_EMPTY) & active;

  generate
    if (SKID != 0) begin : g_skid
      // Registered-state decode only: no combinational path from out_ready.
      assign in_ready = (state_q != ST_TWO) & active;
    end else begin : g_noskid
      // Without a skid entry a full register can only accept when it is
      // emptied in the same cycle.
      assign in_ready = ((state_q == ST_EMPTY) | out_ready) & active;
    end
  endgenerate

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign occupancy = rst ? occ_raw : 2'd0;
  assign out_data  = rst ? head_q  : FLUSH_VAL;
  assign flush_cnt = flush_cnt_q;

  assign flush_sum = {1'b0, flush_cnt_q} + {15'd0, occ_raw};

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      head_d      = FLUSH_VAL;
      skid_d      = FLUSH_VAL;
      flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end else begin
      // freeze needs no branch: it forces push and pop low, so state holds.
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            head_d  = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            // Only reachable with a skid entry; without one, push in ONE
            // always coincides with pop.
            if (SKID != 0) begin
              state_d = ST_TWO;
              skid_d  = in_data;
            end
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one instance with a skid entry (dut_a) and one
// single-register instance with a non-zero flush value (dut_b). Each cycle
// a small behavioural model predicts the handshakes, occupancy and flush
// count; accepted payloads are queued and compared against out_data.
module tb_pipe_stage_reg;

  localparam int          W      = 32;
  localparam logic [W-1:0] FV_A  = '0;
  localparam logic [W-1:0] FV_B  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_flush, a_freeze, a_in_valid, a_out_ready;
  logic [W-1:0] a_in_data;
  logic         a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;
  logic [1:0]   a_occupancy;
  logic [15:0]  a_flush_cnt;

  logic         b_flush, b_freeze, b_in_valid, b_out_ready;
  logic [W-1:0] b_in_data;
  logic         b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;
  logic [1:0]   b_occupancy;
  logic [15:0]  b_flush_cnt;

  pipe_stage_reg #(.DATA_W(W), .SKID(1), .FLUSH_VAL(FV_A)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .freeze(a_freeze),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occupancy), .flush_cnt(a_flush_cnt)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(0), .FLUSH_VAL(FV_B)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .freeze(b_freeze),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy), .flush_cnt(b_flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           occ_a = 0, occ_b = 0;
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  logic [15:0]  fc_a = 16'd0, fc_b = 16'd0;
  bit           clean_a = 1'b1, clean_b = 1'b1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_add(input logic [15:0] c, input int n);
    int s;
    s = int'(c) + n;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  // One clock cycle: check outputs against the model with the inputs the
  // caller has set, advance the model, then cross the rising edge.
  task automatic step();
    logic eov, eir;
    #1;
    // ---- skid instance ----
    eov = rst && (occ_a != 0) && !a_freeze && !a_flush;
    eir = rst && (occ_a != 2) && !a_freeze && !a_flush;
    chk("a_out_valid", W'(a_out_valid), W'(eov));
    chk("a_in_ready",  W'(a_in_ready),  W'(eir));
    chk("a_occupancy", W'(a_occupancy), rst ? W'(occ_a) : '0);
    chk("a_flush_cnt", W'(a_flush_cnt), W'(fc_a));
    if (rst && occ_a != 0) chk("a_out_data", a_out_data, q_a[0]);
    else if (clean_a || !rst) chk("a_out_data_flushval", a_out_data, FV_A);
    if (!rst) begin
      occ_a = 0; q_a.delete(); fc_a = 16'd0; clean_a = 1'b1;
    end else if (a_flush) begin
      fc_a = sat_add(fc_a, occ_a); occ_a = 0; q_a.delete(); clean_a = 1'b1;
    end else begin
      if (eov && a_out_ready) begin void'(q_a.pop_front()); occ_a--; end
      if (eir && a_in_valid) begin q_a.push_back(a_in_data); occ_a++; clean_a = 1'b0; end
    end
    // ---- single-register instance ----
    eov = rst && (occ_b != 0) && !b_freeze && !b_flush;
    eir = rst && ((occ_b == 0) || b_out_ready) && !b_freeze && !b_flush;
    chk("b_out_valid", W'(b_out_valid), W'(eov));
    chk("b_in_ready",  W'(b_in_ready),  W'(eir));
    chk("b_occupancy", W'(b_occupancy), rst ? W'(occ_b) : '0);
    chk("b_flush_cnt", W'(b_flush_cnt), W'(fc_b));
    if (rst && occ_b != 0) chk("b_out_data", b_out_data, q_b[0]);
    else if (clean_b || !rst) chk("b_out_data_flushval", b_out_data, FV_B);
    if (!rst) begin
      occ_b = 0; q_b.delete(); fc_b = 16'd0; clean_b = 1'b1;
    end else if (b_flush) begin
      fc_b = sat_add(fc_b, occ_b); occ_b = 0; q_b.delete(); clean_b = 1'b1;
    end else begin
      if (eov && b_out_ready) begin void'(q_b.pop_front()); occ_b--; end
      if (eir && b_in_valid) begin q_b.push_back(b_in_data); occ_b++; clean_b = 1'b0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic fz);
    a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_flush = fl; a_freeze = fz;
  endtask

  task automatic drive_b(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic fz);
    b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_flush = fl; b_freeze = fz;
  endtask

  initial begin
    // Reset with traffic offered on both instances.
    rst = 1'b0;
    drive_a(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
    drive_b(1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    step();
    step();

    // Release reset with nothing offered.
    rst = 1'b1;
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();

    // Streaming A1..A8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, 32'hA000_0000 + i, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    step();

    // Backpressure: B1, B2 fill both entries, B3 is refused.
    drive_a(1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b1, 32'hB000_0002, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b1, 32'hB000_0003, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); step(); step();

    // Flush with freeze and a new offer while holding two entries.
    drive_a(1'b1, 32'hD000_0001, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b1, 32'hD000_0002, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b1, 32'hD000_0003, 1'b1, 1'b1, 1'b1); step();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); step();

    // Freeze for three cycles while holding C1.
    drive_a(1'b1, 32'hC000_0001, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b1, 32'hC000_0002, 1'b1, 1'b0, 1'b1);
    step(); step(); step();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); step();

    // Repeated flushes: 2-entry, 1-entry and empty.
    for (int i = 0; i < 20; i++) begin
      drive_a(1'b1, 32'hF000_0000 + 2*i,     1'b0, 1'b0, 1'b0); step();
      drive_a(1'b1, 32'hF000_0001 + 2*i,     1'b0, 1'b0, 1'b0); step();
      drive_a(1'b0, '0, 1'b0, 1'b1, 1'b0); step();
    end
    drive_a(1'b1, 32'hF100_0000, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b0, '0, 1'b0, 1'b1, 1'b0); step();
    drive_a(1'b0, '0, 1'b0, 1'b1, 1'b0); step();

    // Saturation: preload the counter near the top, then keep flushing
    // two entries at a time so it crosses 16'hFFFF.
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0);
    force dut_a.flush_cnt_q = 16'hFFF0;
    fc_a = 16'hFFF0;
    step();
    release dut_a.flush_cnt_q;
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, 32'hE000_0000 + i, 1'b0, 1'b0, 1'b0); step();
      drive_a(1'b1, 32'hE100_0000 + i, 1'b0, 1'b0, 1'b0); step();
      drive_a(1'b0, '0, 1'b0, 1'b1, 1'b0); step();
    end

    // Single-register instance: full with out_ready low refuses input,
    // then pop and push in the same cycle.
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_b(1'b1, 32'h5000_0001, 1'b0, 1'b0, 1'b0); step();
    drive_b(1'b1, 32'h5000_0002, 1'b0, 1'b0, 1'b0); step();
    drive_b(1'b1, 32'h5000_0002, 1'b1, 1'b0, 1'b0); step();
    drive_b(1'b1, 32'h5000_0003, 1'b1, 1'b0, 1'b0); step();
    drive_b(1'b1, 32'h5000_0004, 1'b1, 1'b1, 1'b0); step();
    drive_b(1'b1, 32'h5000_0005, 1'b1, 1'b0, 1'b1); step();
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0); step(); step();

    // Reset mid-operation: held entries vanish, flush counts clear.
    drive_a(1'b1, 32'h7000_0001, 1'b0, 1'b0, 1'b0);
    drive_b(1'b1, 32'h7100_0001, 1'b0, 1'b0, 1'b0); step();
    drive_a(1'b1, 32'h7000_0002, 1'b0, 1'b0, 1'b0); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128: payload width in bits; legal range 1..512.
REQ-002 Parameter SKID, default 1: 1 gives a 2-entry skid buffer; 0 gives a single register with no skid entry.
REQ-003 Parameter FLUSH_VAL, default all-zero DATA_W: value loaded into the data registers on reset and on flush.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low: sampled on the rising edge of clk; 0 resets the block.
REQ-006 flush  input  1  discard all held entries this cycle.
REQ-007 freeze  input  1  stall: hold all state, accept nothing, emit nothing.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  DATA_W  head-entry payload.
REQ-014 occupancy  output  2  number of held entries: 0, 1 or 2.
REQ-015 flush_cnt  output  16  count of valid entries discarded by flush; saturates.

Function
REQ-016 The block SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 State SHALL be EMPTY, ONE or TWO; TWO is reachable only when SKID=1; occupancy SHALL encode the state as 0, 1 or 2.
REQ-018 out_valid SHALL equal (state != EMPTY) & ~freeze & ~flush & rst.
REQ-019 With SKID=1, in_ready SHALL equal (state != TWO) & ~freeze & ~flush & rst, decoded from registered state only.
REQ-020 With SKID=0, in_ready SHALL equal (state == EMPTY | out_ready) & ~freeze & ~flush & rst.
REQ-021 out_data SHALL always present the head register; its value is don't-care-free and holds FLUSH_VAL while EMPTY after reset or flush.
REQ-022 Transitions from EMPTY: push -> ONE, head <= in_data.
REQ-023 Transitions from ONE: push & pop -> ONE, head <= in_data; push & ~pop -> TWO, skid <= in_data; pop & ~push -> EMPTY.
REQ-024 Transitions from TWO: pop -> ONE, head <= skid; push cannot occur because in_ready = 0.
REQ-025 Data SHALL leave in strict arrival order, with no duplication and no loss except by flush.
REQ-026 Latency SHALL be 1 cycle: data pushed in cycle N appears on out_data with out_valid = 1 in cycle N+1 when not frozen or flushed.
REQ-027 While freeze = 1 (and flush = 0), the block SHALL hold state, head, skid, occupancy and flush_cnt unchanged.
REQ-028 Flush SHALL take priority over freeze, push and pop.
REQ-029 On flush, the block SHALL load FLUSH_VAL into head and skid, set state to EMPTY, and discard in_data offered in that cycle.
REQ-030 On flush, flush_cnt SHALL increase by occupancy (0, 1 or 2), saturating at 16'hFFFF.
REQ-031 Simultaneous flush and freeze SHALL behave as flush alone.

Reset
REQ-032 When rst = 0 at a rising edge, the block SHALL set state EMPTY, head = skid = FLUSH_VAL and flush_cnt = 0.
REQ-033 While rst = 0: out_valid = 0, in_ready = 0, occupancy = 0, out_data = FLUSH_VAL.
REQ-034 Reset asserted mid-operation SHALL discard all held entries without incrementing flush_cnt.
REQ-035 in_ready SHALL first rise in the cycle after the first edge with rst = 1, provided freeze and flush are 0.

Verification
REQ-036 Reset scenario: hold rst = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, in_ready = 0, flush_cnt = 0, out_data = 0.
REQ-037 Streaming scenario, SKID = 1, out_ready = 1: push A1..A8 back-to-back -> A1..A8 appear in order, each 1 cycle after push, occupancy stays 1.
REQ-038 Backpressure scenario, SKID = 1: push B1, B2 with out_ready = 0 -> occupancy = 2, in_ready = 0, out_data = B1; raise out_ready -> B1 then B2 out; occupancy goes 1 then 0.
REQ-039 Flush scenario: occupancy = 2, then flush = 1 with freeze = 1 and in_valid = 1 -> next cycle occupancy = 0, flush_cnt = 2, offered data never appears; 32769 further 2-entry flushes -> flush_cnt = 16'hFFFF.
REQ-040 Freeze scenario: occupancy = 1 holding C1, freeze = 1 for 3 cycles with out_ready = 1 and in_valid = 1 -> out_valid = 0, in_ready = 0, occupancy = 1; release -> C1 delivered.
REQ-041 Single-register scenario, SKID = 0: out_ready = 0 with 1 entry held -> in_ready = 0; raise out_ready with in_valid = 1 -> pop and push in the same cycle, occupancy stays 1.
